// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the TileLink master-port arbiter.
// Requester indices, A-channel opcodes and the controller state encoding.
package bus_arb_pkg;

    localparam logic [1:0] REQ_IF   = 2'd0;
    localparam logic [1:0] REQ_DM   = 2'd1;
    localparam logic [1:0] REQ_PTW  = 2'd2;
    localparam logic [1:0] REQ_NONE = 2'd3;

    localparam logic [2:0] TL_GET          = 3'd4;
    localparam logic [2:0] TL_PUT_FULL     = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL  = 3'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic [2:0] req_onehot(input logic [1:0] idx);
        logic [2:0] oh;
        oh = 3'b000;
        case (idx)
            REQ_IF:  oh = 3'b001;
            REQ_DM:  oh = 3'b010;
            REQ_PTW: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    function automatic logic is_put(input logic [2:0] opcode);
        return (opcode == TL_PUT_FULL) || (opcode == TL_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_beat_calc.sv
// Combinational TileLink a_size -> bus beat count for a DATA_BYTES-wide beat.
// Sizes needing more beats than the output can express saturate to all-ones.
module tl_beat_calc #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned SIZE_W     = 4
) (
    input  logic [SIZE_W-1:0] size,
    output logic [SIZE_W:0]   beats
);

    localparam int unsigned LG_BYTES = $clog2(DATA_BYTES);
    localparam int unsigned BW       = SIZE_W + 1;

    logic [31:0] size_ext;
    logic [31:0] shift;

    always_comb begin
        size_ext = 32'(size);
        shift    = 32'd0;
        beats    = BW'(1);
        if (size_ext > LG_BYTES) begin
            shift = size_ext - LG_BYTES;
            if (shift >= BW) begin
                beats = '1;
            end else begin
                beats = BW'(1) << shift;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_ctl.sv
// Grant sequencer for the shared TileLink master port: fixed priority ptw > dmem > fetch,
// with fetch aging, holding the grant across every A and D beat of a transaction.
module bus_arbiter_ctl
    import bus_arb_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned SIZE_W     = 4,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        req,
    input  logic              a_valid,
    input  logic              a_ready,
    input  logic [2:0]        a_opcode,
    input  logic [SIZE_W-1:0] a_size,
    input  logic              d_valid,
    input  logic              d_ready,
    output logic [2:0]        grant,
    output logic [1:0]        owner,
    output logic              busy
);

    localparam int unsigned BW       = SIZE_W + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 2);

    localparam logic [BW-1:0]       BEAT_ONE   = BW'(1);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_e          state;
    logic [BW-1:0]       a_beats;
    logic [BW-1:0]       d_beats;
    logic                a_seen;
    logic [STARVE_W-1:0] starve_cnt;

    logic                a_fire;
    logic                d_fire;
    logic                owner_req;
    logic [BW-1:0]       size_beats;
    logic [1:0]          win;

    assign a_fire    = a_valid & a_ready;
    assign d_fire    = d_valid & d_ready;
    assign owner_req = |(req & grant);

    tl_beat_calc #(
        .DATA_BYTES (DATA_BYTES),
        .SIZE_W     (SIZE_W)
    ) u_beat_calc (
        .size  (a_size),
        .beats (size_beats)
    );

    // Aged fetch overrides the fixed priority order.
    always_comb begin
        win = REQ_NONE;
        if (req[0] && (starve_cnt == STARVE_LIM)) begin
            win = REQ_IF;
        end else if (req[2]) begin
            win = REQ_PTW;
        end else if (req[1]) begin
            win = REQ_DM;
        end else if (req[0]) begin
            win = REQ_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 3'b000;
            owner      <= REQ_NONE;
            busy       <= 1'b0;
            a_beats    <= '0;
            d_beats    <= '0;
            a_seen     <= 1'b0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!req[0] || (win == REQ_IF)) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != STARVE_LIM) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                    if (req != 3'b000) begin
                        state  <= ADDR;
                        grant  <= req_onehot(win);
                        owner  <= win;
                        busy   <= 1'b1;
                        a_seen <= 1'b0;
                    end
                end

                ADDR: begin
                    if (a_fire) begin
                        if (!a_seen) begin
                            if (a_opcode == TL_GET) begin
                                d_beats <= size_beats;
                                state   <= RESP;
                            end else if (is_put(a_opcode) && (size_beats != BEAT_ONE)) begin
                                // First beat already accepted; keep the remainder.
                                a_beats <= size_beats - BEAT_ONE;
                                a_seen  <= 1'b1;
                            end else begin
                                d_beats <= BEAT_ONE;
                                state   <= RESP;
                            end
                        end else if (a_beats == BEAT_ONE) begin
                            a_beats <= '0;
                            d_beats <= BEAT_ONE;
                            state   <= RESP;
                        end else begin
                            a_beats <= a_beats - BEAT_ONE;
                        end
                    end else if (!a_seen && !owner_req) begin
                        state <= IDLE;
                        grant <= 3'b000;
                        owner <= REQ_NONE;
                        busy  <= 1'b0;
                    end
                end

                RESP: begin
                    if (d_fire) begin
                        if (d_beats == BEAT_ONE) begin
                            state   <= IDLE;
                            grant   <= 3'b000;
                            owner   <= REQ_NONE;
                            busy    <= 1'b0;
                            d_beats <= '0;
                            a_seen  <= 1'b0;
                        end else begin
                            d_beats <= d_beats - BEAT_ONE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= 3'b000;
                    owner <= REQ_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_ctl.sv
// Directed bench for bus_arbiter_ctl: a per-cycle vector table plus hand-written
// sequences for fetch aging and a stalled multi-beat response.
module tb_bus_arbiter_ctl;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       a_valid;
    logic       a_ready;
    logic [2:0] a_opcode;
    logic [3:0] a_size;
    logic       d_valid;
    logic       d_ready;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;

    int checks;
    int failures;

    bus_arbiter_ctl #(
        .DATA_BYTES (8),
        .SIZE_W     (4),
        .STARVE_MAX (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_opcode (a_opcode),
        .a_size   (a_size),
        .d_valid  (d_valid),
        .d_ready  (d_ready),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rn;
        logic [2:0] rq;
        logic       av;
        logic       ar;
        logic [2:0] op;
        logic [3:0] sz;
        logic       dv;
        logic       dr;
        logic [2:0] eg;
        logic [1:0] eo;
        logic       eb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rn, input logic [2:0] rq, input logic av,
                                input logic ar, input logic [2:0] op, input logic [3:0] sz,
                                input logic dv, input logic dr, input logic [2:0] eg,
                                input logic [1:0] eo, input logic eb);
        vec_t v;
        v = '{rn: rn, rq: rq, av: av, ar: ar, op: op, sz: sz, dv: dv, dr: dr,
              eg: eg, eo: eo, eb: eb};
        return v;
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rn, input logic [2:0] rq, input logic av, input logic ar,
                        input logic [2:0] op, input logic [3:0] sz, input logic dv,
                        input logic dr);
        rst_n    = rn;
        req      = rq;
        a_valid  = av;
        a_ready  = ar;
        a_opcode = op;
        a_size   = sz;
        d_valid  = dv;
        d_ready  = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] eg, input logic [1:0] eo,
                         input logic eb);
        checks++;
        if (grant !== eg || owner !== eo || busy !== eb) begin
            failures++;
            $display("FAIL %s: got grant=%b owner=%0d busy=%b, want grant=%b owner=%0d busy=%b",
                     name, grant, owner, busy, eg, eo, eb);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 3'b000;
        a_valid  = 1'b0;
        a_ready  = 1'b0;
        a_opcode = 3'd4;
        a_size   = 4'd0;
        d_valid  = 1'b0;
        d_ready  = 1'b0;

        //               rn  req     av ar op    sz     dv dr  grant   own   busy
        // reset
        vecs.push_back(mk(0, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        // fetch single-beat Get
        vecs.push_back(mk(1, 3'b001, 0, 0, 3'd4, 4'd0, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b001, 1, 1, 3'd4, 4'd3, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b001, 0, 0, 3'd4, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        // all request: ptw first, then dmem
        vecs.push_back(mk(1, 3'b111, 0, 0, 3'd4, 4'd0, 0, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(1, 3'b111, 1, 1, 3'd4, 4'd3, 0, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(1, 3'b011, 0, 0, 3'd4, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        vecs.push_back(mk(1, 3'b011, 0, 0, 3'd4, 4'd0, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b011, 1, 1, 3'd4, 4'd0, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b011, 0, 0, 3'd4, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        // dmem PutFullData size 5: four A beats, stray D beats in ADDR ignored
        vecs.push_back(mk(1, 3'b010, 0, 0, 3'd0, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b010, 1, 0, 3'd0, 4'd5, 1, 1, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b010, 1, 1, 3'd0, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b010, 1, 1, 3'd0, 4'd5, 1, 1, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b000, 1, 1, 3'd0, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b000, 1, 1, 3'd0, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd0, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        // fetch cancelled before any A beat
        vecs.push_back(mk(1, 3'b001, 0, 0, 3'd4, 4'd0, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        // fetch drops req after A beat: grant held until D beat
        vecs.push_back(mk(1, 3'b001, 0, 0, 3'd4, 4'd0, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b001, 1, 1, 3'd4, 4'd3, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0, 3'b001, 2'd0, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        // reset while in RESP
        vecs.push_back(mk(1, 3'b100, 0, 0, 3'd4, 4'd0, 0, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(1, 3'b100, 1, 1, 3'd4, 4'd3, 0, 0, 3'b100, 2'd2, 1));
        vecs.push_back(mk(0, 3'b100, 0, 0, 3'd4, 4'd0, 0, 0, 3'b000, 2'd3, 0));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd4, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        // other opcode with large size: single A, single D
        vecs.push_back(mk(1, 3'b010, 0, 0, 3'd2, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b010, 1, 1, 3'd2, 4'd5, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd2, 4'd0, 1, 1, 3'b000, 2'd3, 0));
        // PutPartialData within one beat
        vecs.push_back(mk(1, 3'b010, 0, 0, 3'd1, 4'd3, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b010, 1, 1, 3'd1, 4'd3, 0, 0, 3'b010, 2'd1, 1));
        vecs.push_back(mk(1, 3'b000, 0, 0, 3'd1, 4'd0, 1, 1, 3'b000, 2'd3, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rn, vecs[i].rq, vecs[i].av, vecs[i].ar, vecs[i].op, vecs[i].sz,
                 vecs[i].dv, vecs[i].dr);
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eo, vecs[i].eb);
        end

        // Fetch aging: four dmem wins, then fetch forced, then dmem again.
        step(0, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0);
        check("starve_reset", 3'b000, 2'd3, 1'b0);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] eg;
            logic [1:0] eo;
            eg = (k == 4) ? 3'b001 : 3'b010;
            eo = (k == 4) ? 2'd0 : 2'd1;
            step(1, 3'b011, 0, 0, 3'd4, 4'd0, 0, 0);
            check($sformatf("starve_grant%0d", k), eg, eo, 1'b1);
            step(1, 3'b011, 1, 1, 3'd4, 4'd0, 0, 0);
            check($sformatf("starve_resp%0d", k), eg, eo, 1'b1);
            step(1, 3'b011, 0, 0, 3'd4, 4'd0, 1, 1);
            check($sformatf("starve_dead%0d", k), 3'b000, 2'd3, 1'b0);
        end

        // Fetch Get size 6 on an 8-byte bus: eight D beats with d_ready stalls.
        step(0, 3'b000, 0, 0, 3'd4, 4'd0, 0, 0);
        check("burst_reset", 3'b000, 2'd3, 1'b0);
        step(1, 3'b001, 0, 0, 3'd4, 4'd0, 0, 0);
        check("burst_grant", 3'b001, 2'd0, 1'b1);
        step(1, 3'b001, 1, 1, 3'd4, 4'd6, 0, 0);
        check("burst_addr", 3'b001, 2'd0, 1'b1);
        begin
            int fires;
            fires = 0;
            for (int i = 0; i < 24 && fires < 8; i++) begin
                logic dr;
                dr = ((i % 3) != 1);
                step(1, 3'b001, 0, 0, 3'd4, 4'd0, 1'b1, dr);
                if (dr) fires++;
                if (fires < 8) check($sformatf("burst_hold%0d", i), 3'b001, 2'd0, 1'b1);
                else check("burst_done", 3'b000, 2'd3, 1'b0);
            end
        end
        step(1, 3'b000, 0, 0, 3'd4, 4'd0, 1, 1);
        check("burst_idle", 3'b000, 2'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_ctl.md
Name: bus_arbiter_ctl

Overview:
- Sequencing and arbitration controller for the single TileLink master port shared by instruction fetch, the data load/store unit and the page-table walker.
- Owns only the grant; it does not carry the datapath. It watches A/D channel handshakes so that a grant stays held until its whole transaction finishes.
- Sits beside the fetch stage, between the requester `request` lines and the TileLink channel mux wrapper.
- Uses fixed priority with anti-starvation aging for fetch.

Parameters:
- DATA_BYTES, 8, bus beat width in bytes; must be a power of two ≥ 8.
- SIZE_W, 4, width of the TileLink a_size field (log2 bytes).
- STARVE_MAX, 4, consecutive lost arbitrations after which fetch is forced to win.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- req  input  3  request per requester: [0] fetch, [1] dmem, [2] ptw
- a_valid  input  1  A channel valid (from the muxed master)
- a_ready  input  1  A channel ready (from the slave)
- a_opcode  input  3  A opcode: Get=4, PutFullData=0, PutPartialData=1
- a_size  input  SIZE_W  A size, log2 bytes
- d_valid  input  1  D channel valid
- d_ready  input  1  D channel ready
- grant  output  3  one-hot grant, registered
- owner  output  2  index of the granted requester; 3 when none
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, grant=0, owner=3, busy=0, beat counters=0, starve_cnt=0. Reset mid-transaction drops the grant on the next edge with no completion; the bus side is reset by the same rst_n.
- Definitions: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready.
- beats(size) = 1 if 2^size ≤ DATA_BYTES, else 2^size / DATA_BYTES. Computed from a_size at the first a_fire.
- State IDLE:
  - When req≠0, the winner is registered and the state moves to ADDR. grant is asserted the cycle after req is seen (1-cycle latency).
  - Priority: ptw > dmem > fetch.
  - Override: if req[0] is high and starve_cnt==STARVE_MAX, fetch wins.
- starve_cnt:
  - Increments when fetch is requesting and loses arbitration; saturates at STARVE_MAX.
  - Clears when fetch wins or req[0] is low in IDLE.
- State ADDR (grant held):
  - If the owner drops req before any a_fire (fetch cancelled by branch or trap), go to IDLE next cycle and clear grant. No starve_cnt change.
  - Get: the first a_fire latches d_beats=beats(a_size) and goes to RESP.
  - Put: the first a_fire latches a_beats=beats(a_size). Each a_fire decrements it; the a_fire that brings it to zero goes to RESP with d_beats=1.
  - Once any a_fire has occurred, a dropped req is ignored; the transaction must complete.
- State RESP:
  - Each d_fire decrements d_beats. The d_fire that brings it to zero moves to IDLE, and grant/owner clear on that same edge.
  - A new winner is chosen no earlier than the following IDLE cycle (1 dead cycle between transactions).
- Other opcodes in ADDR are treated as single-beat A with single-beat D.
- A d_fire in ADDR, or with no transaction open, is ignored.
- grant is always one-hot or zero. owner is consistent with grant every cycle.

Decomposition:
- Shared package `bus_arb_pkg`:
  - requester index constants (REQ_IF=0, REQ_DM=1, REQ_PTW=2, REQ_NONE=3);
  - TileLink opcode constants;
  - state enum {IDLE, ADDR, RESP}.
- One sub-module `tl_beat_calc`: combinational a_size → beat count (width SIZE_W+1), reused by the channel mux wrapper.

Test Plan:
- Reset, then req=3'b001 → grant=001 one cycle later, owner=0. Get size 3 → one a_fire, one d_fire → grant=0 on that d_fire edge; busy then low.
- req=3'b111 in IDLE → grant=100, owner=2. After its Get completes, with req=011 → grant=010. Fetch loses twice, starve_cnt=2.
- Hold req=3'b011 with back-to-back single-beat dmem Gets, STARVE_MAX=4 → after 4 dmem grants, the 5th grant is 001 even though req[1] is high.
- Fetch Get with a_size=6, DATA_BYTES=8 → 8 d_fire beats required. Insert d_ready=0 stalls mid-burst → grant stays 001 until the 8th d_fire.
- dmem PutFullData with a_size=5 → 4 a_fire beats, then 1 d_fire → completes. A d_fire injected during ADDR is ignored.
- Granted fetch drops req before a_valid → grant clears next cycle, state IDLE. Fetch drops req after a_fire → grant held until d_fire. Assert rst_n=0 in RESP → all outputs at reset values next edge.
